// File: rtl/hist_frame_packer.sv
// Histogram frame packer: buffers the controller's word stream in a FIFO and
// serializes it into sync-prefixed, XOR-checksummed byte frames.
module hist_frame_packer #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          SKIP_ZERO  = 1'b1
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             in_valid,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] in_data,
  output logic                             in_ready,
  output logic [7:0]                       m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             m_last,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             overflow
);

  localparam int unsigned WW  = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned BPW = WW / 8;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned IW  = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [PW:0]         DEPTH_C  = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]         THRESH_C = (PW+1)'(FIFO_DEPTH - 3);
  localparam logic [PW:0]         CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0]       PTR_ONE  = PW'(1);
  localparam logic [IW-1:0]       LAST_IDX = IW'(BPW - 1);
  localparam logic [ADDR_WIDTH:0] NBINS    = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SYNC0, S_SYNC1, S_HDR, S_BINS, S_CSUM} state_t;

  logic [WW-1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PW:0]         cnt_q, cnt_d;
  logic                fifo_empty, fifo_full, push, pop;
  logic [WW-1:0]       head;

  state_t              state_q, state_d;
  logic [WW-1:0]       word_q, word_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH:0] bin_cnt_q, bin_cnt_d;
  logic [7:0]          csum_q, csum_d, cur_byte;
  logic [7:0]          m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic                busy_q, fd_q, fd_d, ovf_q, in_ready_q, out_free;

  function automatic logic [7:0] word_byte(input logic [WW-1:0] w, input logic [IW-1:0] i);
    logic [WW-1:0] sh;
    sh = w >> (8 * (BPW - 1 - 32'(i)));
    return sh[7:0];
  endfunction

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_C);
  assign head       = mem_q[rd_ptr_q];
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign push       = in_valid && (!fifo_full || pop);
  assign out_free   = !m_valid_q || m_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!push && pop) cnt_d = cnt_q - CNT_ONE;
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    bin_cnt_d = bin_cnt_q;
    csum_d    = csum_q;
    cur_byte  = '0;
    pop       = 1'b0;
    fd_d      = 1'b0;
    m_valid_d = !out_free;
    m_last_d  = out_free ? 1'b0 : m_last_q;
    m_data_d  = m_data_q;
    unique case (state_q)
      S_IDLE: begin
        bin_cnt_d = '0;
        idx_d     = '0;
        if (!fifo_empty) state_d = S_SYNC0;
      end
      S_SYNC0: begin
        csum_d = '0;
        if (out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = 8'hA5;
          state_d   = S_SYNC1;
        end
      end
      S_SYNC1: begin
        if (out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = 8'h5A;
          pop       = 1'b1;
          word_d    = head;
          idx_d     = '0;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (out_free) begin
          cur_byte  = word_byte(word_q, idx_q);
          m_valid_d = 1'b1;
          m_data_d  = cur_byte;
          csum_d    = csum_q ^ cur_byte;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_BINS;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_BINS: begin
        // First byte of each bin comes straight off the FIFO head so words chain back-to-back.
        if (idx_q == '0) begin
          if (!fifo_empty) begin
            if (SKIP_ZERO && (head[DATA_WIDTH-1:0] == '0)) begin
              pop       = 1'b1;
              bin_cnt_d = bin_cnt_q + 1'b1;
              if (bin_cnt_d == NBINS) state_d = S_CSUM;
            end else if (out_free) begin
              pop       = 1'b1;
              bin_cnt_d = bin_cnt_q + 1'b1;
              word_d    = head;
              cur_byte  = word_byte(head, '0);
              m_valid_d = 1'b1;
              m_data_d  = cur_byte;
              csum_d    = csum_q ^ cur_byte;
              if (LAST_IDX == '0) begin
                if (bin_cnt_d == NBINS) state_d = S_CSUM;
              end else begin
                idx_d = IW'(1);
              end
            end
          end
        end else if (out_free) begin
          cur_byte  = word_byte(word_q, idx_q);
          m_valid_d = 1'b1;
          m_data_d  = cur_byte;
          csum_d    = csum_q ^ cur_byte;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (bin_cnt_q == NBINS) state_d = S_CSUM;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_CSUM: begin
        if (m_valid_q && m_last_q) begin
          if (m_ready) begin
            fd_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = csum_q;
          m_last_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      ovf_q      <= 1'b0;
      state_q    <= S_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      bin_cnt_q  <= '0;
      csum_q     <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      busy_q     <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q      <= cnt_d;
      in_ready_q <= (cnt_d <= THRESH_C);
      ovf_q      <= ovf_q | (in_valid && fifo_full && !pop);
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      bin_cnt_q  <= bin_cnt_d;
      csum_q     <= csum_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      busy_q     <= (state_d != S_IDLE);
      fd_q       <= fd_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_hist_frame_packer.sv
// Directed bench for hist_frame_packer: two instances (SKIP_ZERO 0/1) share
// clock and reset; a byte scoreboard checks the selected instance.
module tb_hist_frame_packer;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 12;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        in_valid  [2];
  logic [15:0] in_data   [2];
  logic        m_ready   [2];
  logic        in_ready  [2];
  logic [7:0]  m_data    [2];
  logic        m_valid   [2];
  logic        m_last    [2];
  logic        busy      [2];
  logic        frame_done[2];
  logic        overflow  [2];

  hist_frame_packer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .m_last(m_last[0]), .busy(busy[0]), .frame_done(frame_done[0]), .overflow(overflow[0]));

  hist_frame_packer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .m_last(m_last[1]), .busy(busy[1]), .frame_done(frame_done[1]), .overflow(overflow[1]));

  int          total = 0;
  int          bad   = 0;
  logic [8:0]  exp_q[$];
  logic [15:0] words[$];
  logic [11:0] cnt_a[16];
  int          sel = 0;
  bit          up_on, rnd_ready, bp_check, hold_pend, fd_exp, up_enb;
  logic [7:0]  hold_data;
  logic        hold_last;
  int          occ, cyc, n_fd, first_hs, last_hs, hdr_cyc, fv_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input logic last);
    exp_q.push_back({last, b});
  endtask

  // Expected bytes for a frame; bins past nbins are fed but not expected.
  task automatic push_frame(input logic [15:0] hdr, input bit skip, input int nbins, input bit feed);
    logic [7:0]  cs;
    logic [15:0] w;
    push_byte(8'hA5, 1'b0);
    push_byte(8'h5A, 1'b0);
    push_byte(hdr[15:8], 1'b0);
    push_byte(hdr[7:0], 1'b0);
    cs = hdr[15:8] ^ hdr[7:0];
    if (feed) words.push_back(hdr);
    for (int i = 0; i < 16; i++) begin
      w = {4'(i), cnt_a[i]};
      if (feed) words.push_back(w);
      if (i < nbins && !(skip && cnt_a[i] == 12'd0)) begin
        push_byte(w[15:8], 1'b0);
        push_byte(w[7:0], 1'b0);
        cs = cs ^ w[15:8] ^ w[7:0];
      end
    end
    if (nbins == 16) push_byte(cs, 1'b1);
  endtask

  task automatic monitor();
    logic [8:0] e;
    check("frame_done", 32'(frame_done[sel]), 32'(fd_exp));
    if (frame_done[sel]) n_fd++;
    if (hold_pend) begin
      check("hold_data", 32'(m_data[sel]), 32'(hold_data));
      check("hold_last", 32'(m_last[sel]), 32'(hold_last));
    end
    if (m_valid[sel] && fv_cyc < 0) fv_cyc = cyc;
    fd_exp = 1'b0;
    if (m_valid[sel] && m_ready[sel]) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("byte", 32'({m_last[sel], m_data[sel]}), 32'(e));
      end
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      fd_exp  = m_last[sel];
    end
    hold_pend = m_valid[sel] && !m_ready[sel];
    hold_data = m_data[sel];
    hold_last = m_last[sel];
  endtask

  // Called at a negedge; upstream model registers in_ready into a one-cycle-late valid.
  task automatic tick();
    if (up_on) begin
      in_valid[sel] = up_enb;
      if (up_enb) in_data[sel] = words.pop_front();
      up_enb = in_ready[sel] && (words.size() > 0);
    end
    if (rnd_ready) m_ready[sel] = 1'($urandom_range(0, 1));
    monitor();
    @(posedge clk);
    if (in_valid[sel]) begin
      occ++;
      if (hdr_cyc < 0) hdr_cyc = cyc + 1;
    end
    @(negedge clk);
    cyc++;
    if (bp_check) check("in_ready_thresh", 32'(in_ready[sel]), 32'(occ <= int'(DEPTH) - 3));
  endtask

  task automatic clear_model();
    exp_q.delete();
    words.delete();
    up_enb = 1'b0; hold_pend = 1'b0; fd_exp = 1'b0; bp_check = 1'b0; rnd_ready = 1'b0;
    occ = 0; n_fd = 0; first_hs = -1; last_hs = -1; hdr_cyc = -1; fv_cyc = -1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; m_ready[i] = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_m_valid"},    32'(m_valid[sel]),    32'd0);
    check({tag, "_m_data"},     32'(m_data[sel]),     32'd0);
    check({tag, "_m_last"},     32'(m_last[sel]),     32'd0);
    check({tag, "_in_ready"},   32'(in_ready[sel]),   32'd1);
    check({tag, "_busy"},       32'(busy[sel]),       32'd0);
    check({tag, "_frame_done"}, 32'(frame_done[sel]), 32'd0);
    check({tag, "_overflow"},   32'(overflow[sel]),   32'd0);
  endtask

  task automatic do_reset();
    clear_model();
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    resetn = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    check({tag, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 6; i++) tick();
  endtask

  initial begin
    resetn = 1'b0;
    cyc = 0;
    up_on = 1'b0;
    clear_model();
    @(negedge clk);

    // continuous sink, all bins emitted
    sel = 0;
    do_reset();
    for (int i = 0; i < 16; i++) cnt_a[i] = 12'(i + 1);
    push_frame(16'hBEEF, 1'b0, 16, 1'b1);
    up_on = 1'b1; m_ready[0] = 1'b1;
    drain("full", 300);
    check("full_latency", 32'(fv_cyc - hdr_cyc), 32'd2);
    check("full_back_to_back", 32'(last_hs - first_hs), 32'd36);
    check("full_fd_count", 32'(n_fd), 32'd1);
    check("full_idle", 32'(busy[0]), 32'd0);

    // zero-bin suppression on the SKIP_ZERO instance
    sel = 1;
    do_reset();
    for (int i = 0; i < 16; i++) cnt_a[i] = 12'd0;
    cnt_a[3] = 12'd5; cnt_a[9] = 12'd7;
    push_frame(16'h1234, 1'b1, 16, 1'b1);
    up_on = 1'b1; m_ready[1] = 1'b1;
    drain("skip", 300);
    check("skip_fd_count", 32'(n_fd), 32'd1);

    // random sink stalls
    sel = 0;
    do_reset();
    for (int i = 0; i < 16; i++) cnt_a[i] = 12'(i + 1);
    push_frame(16'hBEEF, 1'b0, 16, 1'b1);
    up_on = 1'b1; rnd_ready = 1'b1;
    drain("stall", 600);
    check("stall_fd_count", 32'(n_fd), 32'd1);
    rnd_ready = 1'b0;

    // back-pressure: blocked sink, in_ready must track the threshold
    do_reset();
    push_frame(16'hBEEF, 1'b0, 16, 1'b1);
    up_on = 1'b1; m_ready[0] = 1'b0; bp_check = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    check("bp_no_overflow", 32'(overflow[0]), 32'd0);
    check("bp_ready_low", 32'(in_ready[0]), 32'd0);
    bp_check = 1'b0; m_ready[0] = 1'b1;
    drain("bp", 400);
    check("bp_fd_count", 32'(n_fd), 32'd1);
    check("bp_no_overflow_end", 32'(overflow[0]), 32'd0);

    // overflow: ten forced writes into an 8-deep FIFO
    do_reset();
    up_on = 1'b0; m_ready[0] = 1'b0;
    push_frame(16'hBEEF, 1'b0, 7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = (i == 0) ? 16'hBEEF : {4'(i - 1), cnt_a[i - 1]};
      tick();
      if (i == 7) check("ovf_after_8", 32'(overflow[0]), 32'd0);
    end
    in_valid[0] = 1'b0;
    check("ovf_set", 32'(overflow[0]), 32'd1);
    check("ovf_ready_low", 32'(in_ready[0]), 32'd0);
    m_ready[0] = 1'b1;
    drain("ovf", 200);
    for (int i = 0; i < 10; i++) tick();
    check("ovf_sticky", 32'(overflow[0]), 32'd1);
    check("ovf_stalled_busy", 32'(busy[0]), 32'd1);
    check("ovf_stalled_valid", 32'(m_valid[0]), 32'd0);

    // asynchronous reset in the middle of BINS
    do_reset();
    push_frame(16'hBEEF, 1'b0, 16, 1'b1);
    up_on = 1'b1; m_ready[0] = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("mid_busy", 32'(busy[0]), 32'd1);
    #2 resetn = 1'b0;
    #1 check_reset_vals("async");
    @(negedge clk);
    clear_model();
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) cnt_a[i] = 12'((i * 37 + 5) % 4096);
    push_frame(16'hCAFE, 1'b0, 16, 1'b1);
    m_ready[0] = 1'b1;
    drain("after_reset", 300);
    check("after_reset_fd_count", 32'(n_fd), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
